// File: rtl/ps2_kbd.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd
// Purpose  : PS/2 keyboard receiver feeding a byte FIFO, read via an MMU
//            status/data word. Define PS2_KBD_PARITY_CHECK_EN to drop frames
//            with bad odd parity and flag them in dout[10].
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd #(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic        sel,
   input  logic        re,
   output logic [31:0] dout
);
   localparam int c_aw  = $clog2(FIFO_DEPTH);
   localparam int c_wdw = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_wdw-1:0] c_wd_limit = c_wdw'(TIMEOUT_CYCLES);

   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_data   = 2'd1;
   localparam logic [1:0] c_st_parity = 2'd2;
   localparam logic [1:0] c_st_stop   = 2'd3;

   logic             r_clk_meta, r_clk_sync, r_clk_prev;
   logic             r_data_meta, r_data_sync;
   logic [1:0]       r_state, w_state_nxt;
   logic [2:0]       r_bitcnt;
   logic [7:0]       r_shift;
   logic [c_wdw-1:0] r_wdog;
   logic             r_push;
   logic [7:0]       r_push_byte;
   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [c_aw:0]    r_wr_ptr, r_rd_ptr;
   logic             r_ovf;
   logic [31:0]      r_dout;

   logic w_fall, w_timeout, w_shift_en, w_accept, w_parity_ok, w_perr_bit;
   logic w_empty, w_full, w_pop_req, w_pop, w_push, w_ovf_set;
`ifdef PS2_KBD_PARITY_CHECK_EN
   logic r_parity, r_perr, w_perr_set;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_clk_meta  <= 1'b1;
         r_clk_sync  <= 1'b1;
         r_clk_prev  <= 1'b1;
         r_data_meta <= 1'b1;
         r_data_sync <= 1'b1;
      end else begin
         r_clk_meta  <= ps2_clk;
         r_clk_sync  <= r_clk_meta;
         r_clk_prev  <= r_clk_sync;
         r_data_meta <= ps2_data;
         r_data_sync <= r_data_meta;
      end
   end

   assign w_fall    = r_clk_prev & ~r_clk_sync;
   // A falling edge on the same cycle always wins over an expiring watchdog
   assign w_timeout = (r_state != c_st_idle) && !w_fall && (r_wdog == c_wd_limit);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= c_st_idle;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_timeout) begin
         w_state_nxt = c_st_idle;
      end else if (w_fall) begin
         case (r_state)
            c_st_idle:   if (!r_data_sync) w_state_nxt = c_st_data;
            c_st_data:   if (r_bitcnt == 3'd7) w_state_nxt = c_st_parity;
            c_st_parity: w_state_nxt = c_st_stop;
            default:     w_state_nxt = c_st_idle;
         endcase
      end
   end

   always_comb begin
      w_shift_en = 1'b0;
      w_accept   = 1'b0;
`ifdef PS2_KBD_PARITY_CHECK_EN
      w_perr_set = 1'b0;
`endif
      case (r_state)
         c_st_data: w_shift_en = w_fall;
         c_st_stop: begin
            w_accept = w_fall & r_data_sync & w_parity_ok;
`ifdef PS2_KBD_PARITY_CHECK_EN
            w_perr_set = w_fall & r_data_sync & ~w_parity_ok;
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_bitcnt    <= 3'd0;
         r_shift     <= 8'h00;
         r_wdog      <= '0;
         r_push      <= 1'b0;
         r_push_byte <= 8'h00;
      end else begin
         if (r_state == c_st_idle)   r_bitcnt <= 3'd0;
         else if (w_shift_en)        r_bitcnt <= r_bitcnt + 3'd1;
         if (w_shift_en)             r_shift  <= {r_data_sync, r_shift[7:1]};
         if (r_state == c_st_idle || w_fall) r_wdog <= '0;
         else if (r_wdog != c_wd_limit)      r_wdog <= r_wdog + 1'b1;
         r_push <= w_accept;
         if (w_accept) r_push_byte <= r_shift;
      end
   end

`ifdef PS2_KBD_PARITY_CHECK_EN
   assign w_parity_ok = ^{r_shift, r_parity};
   assign w_perr_bit  = r_perr;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_parity <= 1'b0;
         r_perr   <= 1'b0;
      end else begin
         if (r_state == c_st_parity && w_fall) r_parity <= r_data_sync;
         if (w_perr_set)     r_perr <= 1'b1;
         else if (w_pop_req) r_perr <= 1'b0;
      end
   end
`else
   assign w_parity_ok = 1'b1;
   assign w_perr_bit  = 1'b0;
`endif

   // Extra pointer MSB distinguishes full from empty when the low bits match
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                      (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
   assign w_pop_req = sel & re;
   assign w_pop     = w_pop_req & ~w_empty;
   assign w_push    = r_push & (~w_full | w_pop);
   assign w_ovf_set = r_push & w_full & ~w_pop;

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= r_push_byte;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_ovf    <= 1'b0;
         r_dout   <= 32'h0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_ovf_set)      r_ovf <= 1'b1;
         else if (w_pop_req) r_ovf <= 1'b0;
         r_dout <= {21'd0, w_perr_bit, r_ovf, ~w_empty,
                    w_empty ? 8'h00 : r_mem[r_rd_ptr[c_aw-1:0]]};
      end
   end

   assign dout = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kbd
// Purpose  : Directed scoreboard bench for ps2_kbd (FIFO pops checked by a
//            monitor against a queue of expected bytes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd;
   localparam int c_depth   = 8;
   localparam int c_timeout = 200;
   localparam int c_half    = 10;

   logic        clock    = 1'b0;
   logic        reset    = 1'b1;
   logic        ps2_clk  = 1'b1;
   logic        ps2_data = 1'b1;
   logic        sel      = 1'b0;
   logic        re       = 1'b0;
   logic [31:0] dout;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  mon_exp;
   logic [10:0] frame;
   logic [7:0]  v;

   ps2_kbd #(
      .FIFO_DEPTH    (c_depth),
      .TIMEOUT_CYCLES(c_timeout)
   ) u_dut (
      .clock   (clock),
      .reset   (reset),
      .ps2_clk (ps2_clk),
      .ps2_data(ps2_data),
      .sel     (sel),
      .re      (re),
      .dout    (dout)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic do_pop();
      @(negedge clock);
      sel = 1'b1; re = 1'b1;
      @(negedge clock);
      sel = 1'b0; re = 1'b0;
      wait_neg(3);
   endtask

   // With align_pop, sel&re is raised for the single cycle in which the
   // accepted byte reaches the FIFO: 2 sync flops + edge detect + push stage.
   task automatic send_bits(input logic [10:0] f, input int nbits, input bit align_pop);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clock);
         ps2_data = f[i];
         wait_neg(c_half - 1);
         @(negedge clock);
         ps2_clk = 1'b0;
         if (align_pop && i == 10) begin
            wait_neg(3);
            sel = 1'b1; re = 1'b1;
            wait_neg(1);
            sel = 1'b0; re = 1'b0;
            wait_neg(c_half - 4);
         end else begin
            wait_neg(c_half);
         end
         ps2_clk = 1'b1;
      end
      wait_neg(c_half);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par);
      send_bits({1'b1, par, b, 1'b0}, 11, 1'b0);
   endtask

   // Monitor: every pop of a non-empty FIFO must present the oldest expected byte
   initial begin
      forever begin
         @(negedge clock);
         #1;
         if (sel && re && dout[8]) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL pop_unexpected: got 0x%02h, expected no data", dout[7:0]);
            end else begin
               mon_exp = exp_q.pop_front();
               check("pop_data", {24'd0, dout[7:0]}, {24'd0, mon_exp});
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no end of test, expected completion");
      $fatal(1, "simulation time limit");
   end

   initial begin
      reset = 1'b1;
      wait_neg(4);
      check("reset_dout", dout, 32'h0);
      reset = 1'b0;
      wait_neg(2);

      // Single frame, then pop
      exp_q.push_back(8'h1C);
      send_frame(8'h1C, 1'b0);
      wait_neg(5);
      check("frame_1c", dout, 32'h0000011C);
      do_pop();
      check("after_pop", dout, 32'h0);
      do_pop();
      check("empty_pop", dout, 32'h0);

      // Overflow: ninth byte lost
      for (int i = 1; i <= 9; i++) begin
         v = 8'(i);
         if (i <= 8) exp_q.push_back(v);
         send_frame(v, ~^v);
      end
      wait_neg(5);
      check("overflow_set", dout, 32'h00000301);
      do_pop();
      check("overflow_cleared", dout, 32'h00000102);
      for (int i = 0; i < 7; i++) do_pop();
      check("drained", dout, 32'h0);

      // Bad parity frame
      send_frame(8'h1C, 1'b1);
      wait_neg(5);
`ifdef PS2_KBD_PARITY_CHECK_EN
      check("parity_error", dout, 32'h00000400);
`else
      exp_q.push_back(8'h1C);
      check("parity_ignored", dout, 32'h0000011C);
`endif
      do_pop();
      check("parity_pop", dout, 32'h0);

      // Partial frame aborted by watchdog
      frame = {1'b1, 1'b0, 8'h05, 1'b0};
      send_bits(frame, 5, 1'b0);
      wait_neg(c_timeout + 10);
      exp_q.push_back(8'hF0);
      send_frame(8'hF0, 1'b1);
      wait_neg(5);
      check("after_timeout", dout, 32'h000001F0);
      do_pop();
      check("timeout_pop", dout, 32'h0);

      // Reset mid-frame
      frame = {1'b1, 1'b1, 8'h33, 1'b0};
      send_bits(frame, 5, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      wait_neg(3);
      check("reset_mid_frame", dout, 32'h0);
      reset = 1'b0;
      wait_neg(2);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      wait_neg(5);
      check("after_reset", dout, 32'h0000015A);
      do_pop();
      check("reset_pop", dout, 32'h0);

      // Full FIFO with push and pop in the same cycle
      for (int i = 0; i < 8; i++) begin
         v = 8'h11 + 8'(i);
         exp_q.push_back(v);
         send_frame(v, ~^v);
      end
      wait_neg(5);
      check("full_no_ovf", dout, 32'h00000111);
      exp_q.push_back(8'h99);
      frame = {1'b1, 1'b1, 8'h99, 1'b0};
      send_bits(frame, 11, 1'b1);
      wait_neg(5);
      check("push_pop_full", dout, 32'h00000112);
      for (int i = 0; i < 8; i++) do_pop();
      check("final_empty", dout, 32'h0);
      check("queue_empty", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
